mii_rx_frame_assembler: RTL

//   Rx stage directly upstream of the MAC frame checker. Takes the 64b/8-lane data+ctrl word stream,

---
 rtl/mii_rx_frame_assembler.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mii_rx_frame_assembler.sv
// Receive-side frame assembler: finds START/TERM in the 8-lane data+ctrl stream, buffers the frame,
// and reports byte/word counts, FCS and error flags with a single o_frame_valid pulse per frame.
module mii_rx_frame_assembler #(
  parameter int          DATA_WIDTH      = 64,
  parameter int          CTRL_WIDTH      = 8,
  parameter int          FCS_WIDTH       = 32,
  parameter logic [7:0]  START_CODE      = 8'hFB,
  parameter logic [7:0]  TERM_CODE       = 8'hFD,
  parameter int          MAX_WORDS       = 192,
  parameter int          ADDR_WIDTH      = 8,
  parameter int          MIN_FRAME_BYTES = 72
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_rxd,
  input  logic [CTRL_WIDTH-1:0] i_rxc,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_frame_valid,
  output logic [15:0]           o_frame_bytes,
  output logic [ADDR_WIDTH-1:0] o_frame_words,
  output logic [FCS_WIDTH-1:0]  o_fcs,
  output logic                  o_runt,
  output logic                  o_overflow,
  output logic                  o_ctrl_error,
  output logic                  o_busy
);

  // state  | meaning
  // S_IDLE | waiting for START in lane 0
  // S_RECV | storing frame words until TERM
  // S_DROP | discarding words after overflow/ctrl error until TERM
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

  localparam int                LW         = $clog2(CTRL_WIDTH);
  localparam logic [15:0]       WORD_BYTES = 16'(DATA_WIDTH / 8);
  localparam logic [16:0]       MIN_FCS_B  = 17'(8 + FCS_WIDTH / 8);
  localparam logic [ADDR_WIDTH:0] MAX_ADDR = (ADDR_WIDTH+1)'(MAX_WORDS);

  state_t r_state, w_next_state;

  logic [DATA_WIDTH-1:0] r_mem [MAX_WORDS];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [ADDR_WIDTH:0]   r_wr_addr;
  logic [15:0]           r_bytes;
  logic [DATA_WIDTH-1:0] r_prev;
  logic                  r_ovf;
  logic                  r_cerr;

  logic                  r_frame_valid;
  logic [15:0]           r_frame_bytes;
  logic [ADDR_WIDTH-1:0] r_frame_words;
  logic [FCS_WIDTH-1:0]  r_fcs;
  logic                  r_runt;
  logic                  r_overflow;
  logic                  r_ctrl_error;

  logic [LW-1:0]           w_ctrl_lane;
  logic [LW-1:0]           w_term_lane;
  logic                    w_term_any;
  logic                    w_has_ctrl;
  logic                    w_term_at_k;
  logic                    w_is_start;
  logic [DATA_WIDTH-1:0]   w_masked;

  logic                    w_wr_en;
  logic [DATA_WIDTH-1:0]   w_wr_data;
  logic [ADDR_WIDTH-1:0]   w_wr_addr;
  logic                    w_start;
  logic                    w_done;
  logic [15:0]             w_add_bytes;
  logic [LW-1:0]           w_done_lane;
  logic                    w_set_ovf;
  logic                    w_set_cerr;

  logic [16:0]             w_sum;
  logic [15:0]             w_new_bytes;
  logic [2*DATA_WIDTH-1:0] w_cat;
  logic [6:0]              w_fcs_base;
  logic [FCS_WIDTH-1:0]    w_fcs;

  always_comb begin
    w_ctrl_lane = '0;
    w_term_lane = '0;
    w_term_any  = 1'b0;
    for (int i = CTRL_WIDTH-1; i >= 0; i--) begin
      if (i_rxc[i]) w_ctrl_lane = LW'(i);
      if (i_rxc[i] && (i_rxd[8*i +: 8] == TERM_CODE)) begin
        w_term_lane = LW'(i);
        w_term_any  = 1'b1;
      end
    end
    w_has_ctrl  = |i_rxc;
    w_term_at_k = w_term_any && (w_term_lane == w_ctrl_lane);
    w_is_start  = (i_rxc == CTRL_WIDTH'(1)) && (i_rxd[7:0] == START_CODE);
    w_masked    = '0;
    for (int i = 0; i < CTRL_WIDTH; i++) begin
      w_masked[8*i +: 8] = (i < int'(w_ctrl_lane)) ? i_rxd[8*i +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_wr_en      = 1'b0;
    w_wr_data    = i_rxd;
    w_start      = 1'b0;
    w_done       = 1'b0;
    w_add_bytes  = '0;
    w_done_lane  = w_ctrl_lane;
    w_set_ovf    = 1'b0;
    w_set_cerr   = 1'b0;
    if (i_valid) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_start) begin
            w_start      = 1'b1;
            w_wr_en      = 1'b1;
            w_next_state = S_RECV;
          end
        end
        S_RECV: begin
          if (r_wr_addr == MAX_ADDR) begin
            // buffer full: the word is dropped but still counted
            w_set_ovf = 1'b1;
            if (w_term_any) begin
              w_done       = 1'b1;
              w_done_lane  = w_term_lane;
              w_add_bytes  = 16'(w_term_lane);
              w_next_state = S_IDLE;
            end else begin
              w_add_bytes  = WORD_BYTES;
              w_next_state = S_DROP;
            end
          end else if (!w_has_ctrl) begin
            w_wr_en     = 1'b1;
            w_add_bytes = WORD_BYTES;
          end else if (w_term_at_k) begin
            w_wr_en      = 1'b1;
            w_wr_data    = w_masked;
            w_add_bytes  = 16'(w_ctrl_lane);
            w_done       = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_set_cerr   = 1'b1;
            w_add_bytes  = 16'(w_ctrl_lane);
            w_next_state = S_DROP;
          end
        end
        S_DROP: begin
          if (w_term_any) begin
            w_done       = 1'b1;
            w_done_lane  = w_term_lane;
            w_add_bytes  = 16'(w_term_lane);
            w_next_state = S_IDLE;
          end else begin
            w_add_bytes  = WORD_BYTES;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // FCS is the 4 bytes just below the TERM lane in the {current, previous} byte window
  always_comb begin
    w_sum       = {1'b0, r_bytes} + {1'b0, w_add_bytes};
    w_new_bytes = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    w_cat       = {i_rxd, r_prev};
    w_fcs_base  = 7'({w_done_lane, 3'b000}) + 7'(FCS_WIDTH);
    w_fcs       = ({1'b0, w_new_bytes} < MIN_FCS_B) ? '0 : w_cat[w_fcs_base +: FCS_WIDTH];
    w_wr_addr   = w_start ? '0 : r_wr_addr[ADDR_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_addr     <= '0;
      r_bytes       <= '0;
      r_prev        <= '0;
      r_ovf         <= 1'b0;
      r_cerr        <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_bytes <= '0;
      r_frame_words <= '0;
      r_fcs         <= '0;
      r_runt        <= 1'b0;
      r_overflow    <= 1'b0;
      r_ctrl_error  <= 1'b0;
    end else begin
      r_frame_valid <= w_done;
      if (w_start) begin
        r_wr_addr <= (ADDR_WIDTH+1)'(1);
        r_bytes   <= WORD_BYTES;
        r_prev    <= i_rxd;
        r_ovf     <= 1'b0;
        r_cerr    <= 1'b0;
      end else if (i_valid && (r_state != S_IDLE)) begin
        r_wr_addr <= r_wr_addr + (ADDR_WIDTH+1)'(w_wr_en);
        r_bytes   <= w_new_bytes;
        r_prev    <= i_rxd;
        r_ovf     <= r_ovf | w_set_ovf;
        r_cerr    <= r_cerr | w_set_cerr;
      end
      if (w_done) begin
        r_frame_bytes <= w_new_bytes;
        r_frame_words <= r_wr_addr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(w_wr_en);
        r_fcs         <= w_fcs;
        r_runt        <= (w_new_bytes < 16'(MIN_FRAME_BYTES));
        r_overflow    <= r_ovf | w_set_ovf;
        r_ctrl_error  <= r_cerr | w_set_cerr;
      end
    end
  end

  // buffer itself is never reset; readers only look at words of a completed frame
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= w_wr_data;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)                              r_rd_data <= '0;
    else if (int'(i_rd_addr) < MAX_WORDS)   r_rd_data <= r_mem[i_rd_addr];
    else                                    r_rd_data <= '0;
  end

  assign o_rd_data     = r_rd_data;
  assign o_frame_valid = r_frame_valid;
  assign o_frame_bytes = r_frame_bytes;
  assign o_frame_words = r_frame_words;
  assign o_fcs         = r_fcs;
  assign o_runt        = r_runt;
  assign o_overflow    = r_overflow;
  assign o_ctrl_error  = r_ctrl_error;
  assign o_busy        = (r_state != S_IDLE);

endmodule
